aes_round_ctrl: RTL and testbench

Sequencer for the AES-128 encryption datapath. It accepts one block request through a valid/ready handshake, then steps the round counter that drives `round_sel` and `flag` into `key_expand` and the round datapath. It asserts the per-round enables, signals the final round without MixColumns, and holds the result valid until the consumer accepts it. It sits between the host interface and the key-expansion/round pipeline, and is the only writer of `round_sel`.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_round_cnt.sv | 36 +++
 rtl/aes_round_ctrl.sv | 144 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round sequencer: controller states and
// default round count / round-select width.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } aes_state_t;

  localparam int AES_NR = 10;
  localparam int AES_RW = 4;

endpackage

// File: rtl/aes_round_cnt.sv
// Loadable RW-bit round counter with clear, saturating increment and a
// terminal-count flag that marks the last MixColumns round (NR-1).
module aes_round_cnt #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          load,
  input  logic [RW-1:0] load_val,
  output logic [RW-1:0] cnt,
  output logic          last_round
);

  localparam logic [RW-1:0] NR_V      = RW'(NR);
  localparam logic [RW-1:0] LAST_V    = RW'(NR - 1);

  logic [RW-1:0] cnt_reg;

  // Increment saturates at NR so the counter can never wrap past the final round.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (inc && (cnt_reg < NR_V)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt        = cnt_reg;
  assign last_round = (cnt_reg == LAST_V);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: accepts a block, steps rounds 0..NR, holds the result.
// Optional cancel path (abort/abort_ack) is built only when AES_ABORT_EN is defined.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int RW = AES_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          key_load,
  output logic [RW-1:0] round_sel,
  output logic          flag,
  output logic          key_step,
  output logic          mix_en,
  output logic          final_round,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef AES_ABORT_EN
  input  logic          abort,
  output logic          abort_ack,
`endif
  output logic          busy
);

  localparam logic [RW-1:0] NR_V = RW'(NR);

  aes_state_t state_reg, state_next;
  logic       cnt_clr, cnt_inc, cnt_load, cnt_last;
  logic       flag_reg, key_step_reg, mix_en_reg, final_round_reg;
  logic       out_valid_reg, busy_reg;
`ifdef AES_ABORT_EN
  logic       abort_hit;
  logic       abort_ack_reg;
`endif

  aes_round_cnt #(
    .NR (NR),
    .RW (RW)
  ) u_round_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .load       (cnt_load),
    .load_val   (NR_V),
    .cnt        (round_sel),
    .last_round (cnt_last)
  );

`ifdef AES_ABORT_EN
  assign abort_hit = abort && (state_reg != ST_IDLE);
`endif

  always_comb begin
    state_next = state_reg;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    cnt_load   = 1'b0;
    in_ready   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_INIT;
      end
      ST_INIT: begin
        state_next = ST_ROUND;
        cnt_inc    = 1'b1;
      end
      ST_ROUND: begin
        if (cnt_last) begin
          state_next = ST_FINAL;
          cnt_load   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_FINAL: state_next = ST_DONE;
      ST_DONE: begin
        // Accepting the result frees the controller in the same cycle.
        if (out_ready) begin
          in_ready   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = in_valid ? ST_INIT : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_clr    = 1'b1;
      end
    endcase
`ifdef AES_ABORT_EN
    // Cancel beats everything, including a result hand-off in DONE.
    if (abort_hit) begin
      state_next = ST_IDLE;
      cnt_clr    = 1'b1;
      cnt_inc    = 1'b0;
      cnt_load   = 1'b0;
      in_ready   = 1'b0;
    end
`endif
  end

  assign key_load = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      flag_reg        <= 1'b0;
      key_step_reg    <= 1'b0;
      mix_en_reg      <= 1'b0;
      final_round_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      flag_reg        <= (state_next == ST_ROUND) || (state_next == ST_FINAL) ||
                         (state_next == ST_DONE);
      key_step_reg    <= (state_next == ST_INIT) || (state_next == ST_ROUND);
      mix_en_reg      <= (state_next == ST_ROUND);
      final_round_reg <= (state_next == ST_FINAL);
      out_valid_reg   <= (state_next == ST_DONE);
      busy_reg        <= (state_next != ST_IDLE);
    end
  end

`ifdef AES_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) abort_ack_reg <= 1'b0;
    else     abort_ack_reg <= abort_hit;
  end
  assign abort_ack = abort_ack_reg;
`endif

  assign flag        = flag_reg;
  assign key_step    = key_step_reg;
  assign mix_en      = mix_en_reg;
  assign final_round = final_round_reg;
  assign out_valid   = out_valid_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: directed and random stimulus checked against a
// block-age model (cycles since acceptance). Define AES_ABORT_EN to cover abort.
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          key_load;
  logic [RW-1:0] round_sel;
  logic          flag;
  logic          key_step;
  logic          mix_en;
  logic          final_round;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
`ifdef AES_ABORT_EN
  logic          abort;
  logic          abort_ack;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int age    = 0;     // 0 = idle, else cycles since the block was accepted
  bit ack_exp = 1'b0;
  int last_kl_cyc = -1;
  bit prev_ov = 1'b0;
  int ov_count = 0;

  aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .key_load    (key_load),
    .round_sel   (round_sel),
    .flag        (flag),
    .key_step    (key_step),
    .mix_en      (mix_en),
    .final_round (final_round),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef AES_ABORT_EN
    .abort       (abort),
    .abort_ack   (abort_ack),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, check every output against the age model, advance.
  task automatic step(input bit iv, input bit ordy, input bit r, input bit ab);
    int  exp_rs;
    bit  exp_rdy, exp_kl, ab_eff;
    in_valid  = iv;
    out_ready = ordy;
    rst       = r;
`ifdef AES_ABORT_EN
    abort  = ab;
    ab_eff = ab && (age != 0);
`else
    ab_eff = 1'b0;
`endif
    #1;
    exp_rs  = (age == 0) ? 0 : ((age - 1 > NR) ? NR : age - 1);
    exp_rdy = (age == 0) || (age >= NR + 2 && ordy && !ab_eff);
    exp_kl  = iv && exp_rdy;
    check("in_ready",    in_ready,    exp_rdy);
    check("key_load",    key_load,    exp_kl);
    check("round_sel",   round_sel,   exp_rs);
    check("flag",        flag,        age >= 2);
    check("key_step",    key_step,    age >= 1 && age <= NR);
    check("mix_en",      mix_en,      age >= 2 && age <= NR);
    check("final_round", final_round, age == NR + 1);
    check("out_valid",   out_valid,   age >= NR + 2);
    check("busy",        busy,        age >= 1);
`ifdef AES_ABORT_EN
    check("abort_ack",   abort_ack,   ack_exp);
`endif
    // Latency from acceptance to first out_valid must be NR+2 cycles.
    if (out_valid === 1'b1 && !prev_ov) begin
      ov_count++;
      check("latency", cyc - last_kl_cyc, NR + 2);
    end
    if (out_valid === 1'b1 && ordy && iv && !ab_eff && !r)
      check("b2b_key_load", key_load, 1);
    prev_ov = (out_valid === 1'b1) && !(ordy || ab_eff || r);
    if (key_load === 1'b1 && !r) last_kl_cyc = cyc;
    @(posedge clk);
    if (r) begin
      age = 0; ack_exp = 1'b0; prev_ov = 1'b0;
    end else if (ab_eff) begin
      age = 0; ack_exp = 1'b1; prev_ov = 1'b0;
    end else begin
      ack_exp = 1'b0;
      if (exp_kl)             age = 1;
      else if (age >= NR + 2) age = ordy ? 0 : age;
      else if (age >= 1)      age++;
    end
    cyc++;
    #1;
  endtask

  initial begin
    int ov_before;
    in_valid = 0; out_ready = 0; rst = 1;
`ifdef AES_ABORT_EN
    abort = 0;
`endif
    @(posedge clk); #1;
    step(0, 0, 1, 0);                 // reset values observed here
    step(0, 0, 0, 0);

    // Single block, consumer always ready.
    step(1, 1, 0, 0);
    for (int i = 0; i < NR + 3; i++) step(0, 1, 0, 0);

    // Consumer stalls five cycles after out_valid.
    step(1, 0, 0, 0);
    for (int i = 0; i < NR + 2 + 5; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Back-to-back requests.
    ov_before = ov_count;
    for (int i = 0; i < 4 * (NR + 2) + 1; i++) step(1, 1, 0, 0);
    check("b2b_blocks", ov_count - ov_before, 4);
    for (int i = 0; i < NR + 3; i++) step(0, 1, 0, 0);

    // Reset while round_sel = 5: block must vanish.
    ov_before = ov_count;
    step(1, 1, 0, 0);
    while (age != 6) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < NR + 4; i++) step(0, 1, 0, 0);
    check("rst_no_result", ov_count - ov_before, 0);

`ifdef AES_ABORT_EN
    // Abort at round_sel = 3, then a clean block.
    ov_before = ov_count;
    step(1, 1, 0, 0);
    while (age != 4) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    check("abort_no_result", ov_count - ov_before, 0);
    step(0, 1, 0, 1);                 // abort while idle is ignored
    step(1, 1, 0, 0);
    for (int i = 0; i < NR + 3; i++) step(0, 1, 0, 0);
    check("after_abort_result", ov_count - ov_before, 1);
`endif

    // in_valid pulsed while busy is ignored.
    ov_before = ov_count;
    step(1, 0, 0, 0);
    for (int i = 0; i < NR + 1; i++) step(i % 3 == 0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check("busy_ignored", ov_count - ov_before, 1);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 80) == 0, $urandom_range(0, 25) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
